// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-fetch slice: bus widths, memory geometry
// and the fetch-queue entry layout.
package imem_pkg;

  localparam int XLEN             = 32;
  localparam int INST_BYTES       = 4;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam int IMEM_WORDS       = 1024;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0;
  localparam int MAX_QUEUE_DEPTH  = 8;

  // Wide enough to hold any occupancy from 0 up to MAX_QUEUE_DEPTH.
  typedef logic [3:0] q_count_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Memory-side and decode-side handshake signals of the fetch sequencer.
interface imem_fetch_ctrl_if;
  import imem_pkg::*;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_rdata, inst_ready
  );

endinterface

// File: rtl/imem_fetch_queue.sv
// Small synchronous FIFO of {pc, data} entries with flush; the head output holds
// the last presented entry while the queue is empty.
module imem_fetch_queue
  import imem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head_entry,
  output q_count_t     count,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_reg [DEPTH];
  fetch_entry_t     hold_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  q_count_t         count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == q_count_t'(DEPTH));
  assign count   = count_reg;
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign head_entry = empty ? hold_reg : mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      hold_reg   <= '0;
    end else begin
      // Remember what was on the head so an empty queue keeps presenting it.
      if (!empty) begin
        hold_reg <= mem_reg[rd_ptr_reg];
      end
      if (flush) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
        if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
        count_reg <= count_reg + q_count_t'(do_push) - q_count_t'(do_pop);
      end
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one read per cycle to a 1-cycle-latency
// instruction memory and buffers returned words for decode.
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  imem_fetch_ctrl_if.master bus
);

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] req_addr_reg;
  logic            inflight_reg;

  q_count_t     q_count;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t q_head;
  fetch_entry_t q_push_entry;

  logic       pop;
  logic       push;
  logic       issue;
  logic [4:0] occupancy;

  assign pop = !q_empty && bus.inst_ready;

  // Credit check: queued words plus the word still in flight, minus the one
  // leaving this cycle, must leave room for the read we are about to issue.
  assign occupancy = 5'(q_count) + 5'(inflight_reg) - 5'(pop);
  assign issue     = rst_n && fetch_en && !redirect_valid
                     && (occupancy < 5'(QUEUE_DEPTH));

  assign push         = inflight_reg && !redirect_valid;
  assign q_push_entry = '{pc: req_addr_reg, data: bus.imem_rdata};

  assign bus.imem_req_valid = issue;
  assign bus.imem_addr      = pc_reg;
  assign bus.inst_valid     = !q_empty;
  assign bus.inst_data      = q_head.data;
  assign bus.inst_pc        = q_head.pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg       <= RESET_PC;
      req_addr_reg <= RESET_PC;
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        req_addr_reg <= pc_reg;
      end
      if (redirect_valid) begin
        pc_reg <= align_pc(redirect_pc);
      end else if (issue) begin
        pc_reg <= pc_reg + XLEN'(INST_BYTES);
      end
    end
  end

  imem_fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_entry (q_push_entry),
    .head_entry (q_head),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

  queue_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && q_full && !pop));

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a cycle table for streaming, backpressure,
// redirect, wrap and fetch_en gaps, plus hand sequences for async reset and
// back-to-back redirects.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam int NVEC = 30;

  typedef struct packed {
    logic        en;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_idata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs [NVEC];

  imem_fetch_ctrl_if bus ();

  imem_fetch_ctrl #(
    .RESET_PC    (32'h0),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Memory model: word = addr ^ KEY, returned one cycle after the request.
  always @(posedge clk) begin
    bus.imem_rdata <= bus.imem_req_valid ? (bus.imem_addr ^ KEY) : 32'hDEAD_BEEF;
  end

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  function automatic vec_t mk(input logic en, input logic rdy, input logic rv,
                              input logic [31:0] rpc, input logic req,
                              input logic [31:0] addr, input logic iv,
                              input logic [31:0] ipc, input logic [31:0] idata);
    vec_t v;
    v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_req = req; v.e_addr = addr; v.e_iv = iv; v.e_ipc = ipc; v.e_idata = idata;
    return v;
  endfunction

  task automatic chk(input string name, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int cyc, input logic req,
                         input logic [31:0] addr, input logic iv,
                         input logic [31:0] ipc, input logic [31:0] idata);
    chk({tag, ".req_valid"}, cyc, 32'(bus.imem_req_valid), 32'(req));
    chk({tag, ".addr"},      cyc, bus.imem_addr, addr);
    chk({tag, ".inst_valid"}, cyc, 32'(bus.inst_valid), 32'(iv));
    chk({tag, ".inst_pc"},   cyc, bus.inst_pc, ipc);
    chk({tag, ".inst_data"}, cyc, bus.inst_data, idata);
  endtask

  task automatic drive(input logic en, input logic rdy, input logic rv,
                       input logic [31:0] rpc);
    fetch_en       = en;
    bus.inst_ready = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic show(input string tag, input int cyc);
    $display("%s %0d: req=%b addr=%h inst_valid=%b inst_pc=%h inst_data=%h",
             tag, cyc, bus.imem_req_valid, bus.imem_addr, bus.inst_valid,
             bus.inst_pc, bus.inst_data);
  endtask

  initial begin
    // Streaming, then backpressure on cycles 3..7.
    vecs[0]  = mk(1, 1, 0, 0, 1, 32'h0,  0, 32'h0, 32'h0);
    vecs[1]  = mk(1, 1, 0, 0, 1, 32'h4,  0, 32'h0, 32'h0);
    vecs[2]  = mk(1, 1, 0, 0, 1, 32'h8,  1, 32'h0, w(32'h0));
    vecs[3]  = mk(1, 0, 0, 0, 0, 32'hC,  1, 32'h4, w(32'h4));
    vecs[4]  = mk(1, 0, 0, 0, 0, 32'hC,  1, 32'h4, w(32'h4));
    vecs[5]  = mk(1, 0, 0, 0, 0, 32'hC,  1, 32'h4, w(32'h4));
    vecs[6]  = mk(1, 0, 0, 0, 0, 32'hC,  1, 32'h4, w(32'h4));
    vecs[7]  = mk(1, 0, 0, 0, 0, 32'hC,  1, 32'h4, w(32'h4));
    vecs[8]  = mk(1, 1, 0, 0, 1, 32'hC,  1, 32'h4, w(32'h4));
    vecs[9]  = mk(1, 1, 0, 0, 1, 32'h10, 1, 32'h8, w(32'h8));
    vecs[10] = mk(1, 1, 0, 0, 1, 32'h14, 1, 32'hC, w(32'hC));
    // Redirect with one word queued and one in flight; neither may appear.
    vecs[11] = mk(1, 0, 1, 32'h103, 0, 32'h18, 1, 32'h10, w(32'h10));
    vecs[12] = mk(1, 1, 0, 0, 1, 32'h100, 0, 32'h10, w(32'h10));
    vecs[13] = mk(1, 1, 0, 0, 1, 32'h104, 0, 32'h10, w(32'h10));
    vecs[14] = mk(1, 1, 0, 0, 1, 32'h108, 1, 32'h100, w(32'h100));
    vecs[15] = mk(1, 1, 0, 0, 1, 32'h10C, 1, 32'h104, w(32'h104));
    // Redirect near the top of the address space; PC wraps to zero.
    vecs[16] = mk(1, 1, 1, 32'hFFFF_FFF8, 0, 32'h110, 1, 32'h108, w(32'h108));
    vecs[17] = mk(1, 1, 0, 0, 1, 32'hFFFF_FFF8, 0, 32'h108, w(32'h108));
    vecs[18] = mk(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h108, w(32'h108));
    vecs[19] = mk(1, 1, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFF8, w(32'hFFFF_FFF8));
    vecs[20] = mk(1, 1, 0, 0, 1, 32'h4, 1, 32'hFFFF_FFFC, w(32'hFFFF_FFFC));
    vecs[21] = mk(1, 1, 0, 0, 1, 32'h8, 1, 32'h0, w(32'h0));
    // fetch_en low for 4 cycles: in-flight word still lands, resume at 0xC.
    vecs[22] = mk(0, 1, 0, 0, 0, 32'hC, 1, 32'h4, w(32'h4));
    vecs[23] = mk(0, 1, 0, 0, 0, 32'hC, 1, 32'h8, w(32'h8));
    vecs[24] = mk(0, 1, 0, 0, 0, 32'hC, 0, 32'h8, w(32'h8));
    vecs[25] = mk(0, 1, 0, 0, 0, 32'hC, 0, 32'h8, w(32'h8));
    vecs[26] = mk(1, 1, 0, 0, 1, 32'hC,  0, 32'h8, w(32'h8));
    vecs[27] = mk(1, 1, 0, 0, 1, 32'h10, 0, 32'h8, w(32'h8));
    vecs[28] = mk(1, 1, 0, 0, 1, 32'h14, 1, 32'hC, w(32'hC));
    vecs[29] = mk(1, 1, 0, 0, 1, 32'h18, 1, 32'h10, w(32'h10));

    rst_n = 1'b0;
    drive(0, 0, 0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk_all("reset", -1, 0, 32'h0, 0, 32'h0, 32'h0);
    show("reset", -1);
    #2 rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].en, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      #1;
      show("vec", i);
      chk_all("vec", i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_iv,
              vecs[i].e_ipc, vecs[i].e_idata);
    end

    // Asynchronous reset between clock edges with fetch_en and inst_ready high.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    show("async_rst", 0);
    chk_all("async_rst", 0, 0, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    chk("async_rst.hold_req", 1, 32'(bus.imem_req_valid), 32'h0);
    chk("async_rst.hold_iv",  1, 32'(bus.inst_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    show("post_rst", 0);
    chk("post_rst.req",  0, 32'(bus.imem_req_valid), 32'h1);
    chk("post_rst.addr", 0, bus.imem_addr, 32'h0);
    chk("post_rst.iv",   0, 32'(bus.inst_valid), 32'h0);
    @(negedge clk);
    #1;
    show("post_rst", 1);
    chk("post_rst.addr", 1, bus.imem_addr, 32'h4);
    chk("post_rst.iv",   1, 32'(bus.inst_valid), 32'h0);
    @(negedge clk);
    #1;
    show("post_rst", 2);
    chk("post_rst.iv",    2, 32'(bus.inst_valid), 32'h1);
    chk("post_rst.ipc",   2, bus.inst_pc, 32'h0);
    chk("post_rst.idata", 2, bus.inst_data, w(32'h0));

    // Back-to-back redirects: the second target wins.
    @(negedge clk);
    drive(1, 1, 1, 32'h200);
    #1;
    show("b2b", 0);
    chk("b2b.req", 0, 32'(bus.imem_req_valid), 32'h0);
    @(negedge clk);
    drive(1, 1, 1, 32'h302);
    #1;
    show("b2b", 1);
    chk("b2b.req", 1, 32'(bus.imem_req_valid), 32'h0);
    chk("b2b.iv",  1, 32'(bus.inst_valid), 32'h0);
    @(negedge clk);
    drive(1, 1, 0, 32'h0);
    #1;
    show("b2b", 2);
    chk("b2b.req",  2, 32'(bus.imem_req_valid), 32'h1);
    chk("b2b.addr", 2, bus.imem_addr, 32'h300);
    chk("b2b.iv",   2, 32'(bus.inst_valid), 32'h0);
    @(negedge clk);
    #1;
    show("b2b", 3);
    chk("b2b.addr", 3, bus.imem_addr, 32'h304);
    chk("b2b.iv",   3, 32'(bus.inst_valid), 32'h0);
    @(negedge clk);
    #1;
    show("b2b", 4);
    chk("b2b.iv",    4, 32'(bus.inst_valid), 32'h1);
    chk("b2b.ipc",   4, bus.inst_pc, 32'h300);
    chk("b2b.idata", 4, bus.inst_data, w(32'h300));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
